// File: rtl/cachebusarb_pkg.sv
// Shared types for the cache-line bus arbiter: burst state and bus owner encoding,
// also used by the bus unit.
package cachebusarb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } busStateT;

   typedef enum logic [0:0] {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } busOwnerT;

endpackage

// File: rtl/cachebusarbsel.sv
// Combinational winner select for the cache bus arbiter: a D$ writeback/refill pair,
// then starved I$, then default D$ priority.
module cachebusarbsel
   import cachebusarb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int SCW          = $clog2(STARVE_LIMIT + 1)
) (
   input  logic [1:0]     ICacheBusRW,
   input  logic [1:0]     DCacheBusRW,
   input  logic [SCW-1:0] StarveCnt,
   input  logic           PairPend,
   output logic           ReqAny,
   output busOwnerT       Winner,
   output logic           Write
);

   logic iReq;
   logic dReq;
   logic starved;
   logic unusedIRw0;

   assign iReq       = ICacheBusRW[1];
   assign dReq       = |DCacheBusRW;
   assign starved    = (StarveCnt == SCW'(STARVE_LIMIT));
   assign unusedIRw0 = ICacheBusRW[0];

   // Priority chain; RW=2'b11 from D$ counts as a writeback.
   always_comb begin
      ReqAny = dReq | iReq;
      Winner = OWNER_D;
      Write  = 1'b0;
      if (PairPend && dReq) begin
         Winner = OWNER_D;
      end else if (iReq && starved) begin
         Winner = OWNER_I;
      end else if (dReq) begin
         Winner = OWNER_D;
      end else if (iReq) begin
         Winner = OWNER_I;
      end else begin
         Winner = OWNER_D;
      end
      if (Winner == OWNER_D) begin
         Write = DCacheBusRW[0];
      end else begin
         Write = 1'b0;
      end
   end

endmodule

// File: rtl/cachebusarb.sv
// I$/D$ line-burst arbiter: grants one whole cache line at a time on the shared bus,
// sequences beats, and pulses the owner's Ack on the final accepted beat.
module cachebusarb
   import cachebusarb_pkg::*;
#(
   parameter int  PA_BITS      = 32,
   parameter int  LINELEN      = 512,
   parameter int  AHBW         = 64,
   parameter int  STARVE_LIMIT = 4,
   localparam int BEATS        = LINELEN / AHBW,
   localparam int LOGBWPL      = $clog2(BEATS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         ICacheBusRW,
   input  logic [PA_BITS-1:0] ICacheBusAdr,
   input  logic [1:0]         DCacheBusRW,
   input  logic [PA_BITS-1:0] DCacheBusAdr,
   input  logic               BusReady,
   output logic               BusValid,
   output logic               BusWrite,
   output logic [PA_BITS-1:0] BusAdr,
   output logic [LOGBWPL-1:0] BeatCount,
   output logic               SelBusBeat,
   output logic               IGrant,
   output logic               DGrant,
   output logic               ICacheBusAck,
   output logic               DCacheBusAck
);

   localparam int                 SCW        = $clog2(STARVE_LIMIT + 1);
   localparam logic [PA_BITS-1:0] BEAT_BYTES = PA_BITS'(AHBW / 8);

   busStateT           state;
   busOwnerT           owner;
   logic               writeR;
   logic [SCW-1:0]     starveCnt;
   logic               pairPend;
   logic [PA_BITS-1:0] lineAdr;

   logic     reqAny;
   busOwnerT winner;
   logic     selWrite;
   logic     lastBeat;

   cachebusarbsel #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .SCW          (SCW)
   ) sel (
      .ICacheBusRW (ICacheBusRW),
      .DCacheBusRW (DCacheBusRW),
      .StarveCnt   (starveCnt),
      .PairPend    (pairPend),
      .ReqAny      (reqAny),
      .Winner      (winner),
      .Write       (selWrite)
   );

   assign BusValid   = (state == BURST);
   assign IGrant     = BusValid & (owner == OWNER_I);
   assign DGrant     = BusValid & (owner == OWNER_D);
   assign BusWrite   = BusValid & writeR;
   assign SelBusBeat = DGrant & writeR;
   assign BusAdr     = lineAdr + (PA_BITS'(BeatCount) * BEAT_BYTES);

   // A reset cycle must never complete a burst, so Ack is suppressed while reset is high.
   assign lastBeat     = BusValid & BusReady & (BeatCount == LOGBWPL'(BEATS - 1)) & ~reset;
   assign ICacheBusAck = lastBeat & (owner == OWNER_I);
   assign DCacheBusAck = lastBeat & (owner == OWNER_D);

   // Burst FSM: grant latch in IDLE, beat sequencing in BURST.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWNER_I;
         writeR    <= 1'b0;
         BeatCount <= '0;
         starveCnt <= '0;
         pairPend  <= 1'b0;
         lineAdr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               pairPend <= 1'b0;
               if (reqAny) begin
                  state   <= BURST;
                  owner   <= winner;
                  writeR  <= selWrite;
                  lineAdr <= (winner == OWNER_D) ? DCacheBusAdr : ICacheBusAdr;
                  if (winner == OWNER_I) begin
                     starveCnt <= '0;
                  end else if (ICacheBusRW[1] && (starveCnt != SCW'(STARVE_LIMIT))) begin
                     starveCnt <= starveCnt + SCW'(1);
                  end else begin
                     starveCnt <= starveCnt;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            BURST: begin
               if (BusReady) begin
                  if (BeatCount == LOGBWPL'(BEATS - 1)) begin
                     BeatCount <= '0;
                     state     <= IDLE;
                     // A finished D$ writeback lets its refill win the very next IDLE.
                     pairPend  <= (owner == OWNER_D) & writeR;
                  end else begin
                     BeatCount <= BeatCount + LOGBWPL'(1);
                  end
               end else begin
                  BeatCount <= BeatCount;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cachebusarb.sv
// Bench for cachebusarb: requester queues drive the caches, a scoreboard of expected
// bursts is checked beat by beat at the falling edge.
module tb_cachebusarb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  ICacheBusRW = 2'b00;
   logic [31:0] ICacheBusAdr = 32'h0;
   logic [1:0]  DCacheBusRW = 2'b00;
   logic [31:0] DCacheBusAdr = 32'h0;
   logic        BusReady = 1'b1;
   logic        BusValid, BusWrite, SelBusBeat, IGrant, DGrant, ICacheBusAck, DCacheBusAck;
   logic [31:0] BusAdr;
   logic [2:0]  BeatCount;

   cachebusarb dut (
      .clk(clk), .reset(reset),
      .ICacheBusRW(ICacheBusRW), .ICacheBusAdr(ICacheBusAdr),
      .DCacheBusRW(DCacheBusRW), .DCacheBusAdr(DCacheBusAdr),
      .BusReady(BusReady), .BusValid(BusValid), .BusWrite(BusWrite),
      .BusAdr(BusAdr), .BeatCount(BeatCount), .SelBusBeat(SelBusBeat),
      .IGrant(IGrant), .DGrant(DGrant),
      .ICacheBusAck(ICacheBusAck), .DCacheBusAck(DCacheBusAck)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ownerD;
      logic        write;
      logic [31:0] adr;
   } expT;

   typedef struct packed {
      logic [1:0]  rw;
      logic [31:0] adr;
   } reqT;

   typedef struct {
      logic [1:0]  iRW;
      logic [31:0] iAdr;
      logic [1:0]  dRW;
      logic [31:0] dAdr;
      logic        expD;
      logic        expW;
      logic [31:0] expAdr;
   } vecT;

   expT expQ[$];
   reqT iSeq[$];
   reqT dSeq[$];
   vecT vecs[6];
   expT cur;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int iAckCnt = 0, dAckCnt = 0, iAckSeen = 0, dAckSeen = 0;
   int beatExp = 0, startCyc = 0, ackCyc = 0, gapCyc = 0, loadCyc = 0;
   bit inBurst = 1'b0;
   bit readyMode = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit isDone();
      return (expQ.size() == 0) && !inBurst && (iSeq.size() == 0) && (dSeq.size() == 0)
             && (ICacheBusRW == 2'b00) && (DCacheBusRW == 2'b00);
   endfunction

   task automatic driveReqs();
      reqT r;
      if (reset) begin
         ICacheBusRW = 2'b00;
         DCacheBusRW = 2'b00;
         iAckSeen = iAckCnt;
         dAckSeen = dAckCnt;
      end else begin
         if (iAckCnt != iAckSeen) begin
            iAckSeen = iAckCnt;
            ICacheBusRW = 2'b00;
         end
         if (ICacheBusRW == 2'b00 && iSeq.size() != 0) begin
            r = iSeq.pop_front();
            ICacheBusRW = r.rw;
            ICacheBusAdr = r.adr;
            loadCyc = cyc;
         end
         if (dAckCnt != dAckSeen) begin
            dAckSeen = dAckCnt;
            DCacheBusRW = 2'b00;
         end
         if (DCacheBusRW == 2'b00 && dSeq.size() != 0) begin
            r = dSeq.pop_front();
            DCacheBusRW = r.rw;
            DCacheBusAdr = r.adr;
            loadCyc = cyc;
         end
      end
      BusReady = readyMode ? ~BusReady : 1'b1;
   endtask

   task automatic monitor();
      logic lastBeat;
      if (reset) begin
         chk("ackInReset", 32'({ICacheBusAck, DCacheBusAck}), 32'h0);
         inBurst = 1'b0;
      end else if (BusValid) begin
         if (!inBurst) begin
            chk("burstExpected", 32'(expQ.size() != 0), 32'h1);
            if (expQ.size() != 0) cur = expQ.pop_front();
            else cur = '{1'b0, 1'b0, 32'h0};
            gapCyc = cyc - ackCyc;
            startCyc = cyc;
            inBurst = 1'b1;
            beatExp = 0;
         end
         lastBeat = BusReady && (beatExp == 7);
         chk("grant", 32'({IGrant, DGrant}), 32'({~cur.ownerD, cur.ownerD}));
         chk("busWrite", 32'(BusWrite), 32'(cur.write));
         chk("selBusBeat", 32'(SelBusBeat), 32'(cur.ownerD & cur.write));
         chk("beatCount", 32'(BeatCount), 32'(beatExp));
         chk("busAdr", BusAdr, cur.adr + 32'(beatExp * 8));
         chk("ack", 32'({ICacheBusAck, DCacheBusAck}),
             32'({lastBeat & ~cur.ownerD, lastBeat & cur.ownerD}));
         if (BusReady) begin
            if (beatExp == 7) begin
               inBurst = 1'b0;
               ackCyc = cyc;
               if (cur.ownerD) dAckCnt++;
               else iAckCnt++;
            end else begin
               beatExp++;
            end
         end
      end else begin
         chk("burstDropped", 32'(inBurst), 32'h0);
         inBurst = 1'b0;
         chk("idleOutputs", 32'({IGrant, DGrant, SelBusBeat, BusWrite, ICacheBusAck, DCacheBusAck}), 32'h0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      driveReqs();
      @(negedge clk);
      monitor();
   endtask

   task automatic waitIdle(input int maxCyc, input string name);
      int k = 0;
      while (!isDone() && k < maxCyc) begin
         tick();
         k++;
      end
      chk({"finished_", name}, 32'(isDone()), 32'h1);
   endtask

   task automatic doReset();
      readyMode = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chkAllZero(input string name);
      chk({name, "_outputs"}, 32'({BusValid, BusWrite, SelBusBeat, IGrant, DGrant, ICacheBusAck, DCacheBusAck}), 32'h0);
      chk({name, "_busAdr"}, BusAdr, 32'h0);
      chk({name, "_beatCount"}, 32'(BeatCount), 32'h0);
   endtask

   initial begin
      vecs[0] = '{2'b10, 32'h0000_1000, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0000_1000};
      vecs[1] = '{2'b11, 32'h0000_2040, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0000_2040};
      vecs[2] = '{2'b00, 32'h0, 2'b10, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_3000};
      vecs[3] = '{2'b00, 32'h0, 2'b01, 32'h0000_4000, 1'b1, 1'b1, 32'h0000_4000};
      vecs[4] = '{2'b00, 32'h0, 2'b11, 32'h0000_50C0, 1'b1, 1'b1, 32'h0000_50C0};
      vecs[5] = '{2'b00, 32'h0, 2'b10, 32'hFFFF_FFC0, 1'b1, 1'b0, 32'hFFFF_FFC0};

      doReset();
      chkAllZero("reset");

      // Single-requester transfers with zero wait states.
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].iRW != 2'b00) iSeq.push_back('{vecs[i].iRW, vecs[i].iAdr});
         if (vecs[i].dRW != 2'b00) dSeq.push_back('{vecs[i].dRW, vecs[i].dAdr});
         expQ.push_back('{vecs[i].expD, vecs[i].expW, vecs[i].expAdr});
         waitIdle(40, "vec");
         chk("vecLatency", 32'(startCyc - loadCyc), 32'h1);
         chk("vecLength", 32'(ackCyc - startCyc), 32'h7);
      end

      // Simultaneous fetches: D$ first, I$ after exactly one IDLE cycle.
      doReset();
      iSeq.push_back('{2'b10, 32'h0000_7000});
      dSeq.push_back('{2'b10, 32'h0000_8000});
      expQ.push_back('{1'b1, 1'b0, 32'h0000_8000});
      expQ.push_back('{1'b0, 1'b0, 32'h0000_7000});
      waitIdle(60, "simultaneous");
      chk("oneIdleGap", 32'(gapCyc), 32'h2);

      // Continuous D$ fetches: I$ forced in after four D$ bursts.
      doReset();
      iSeq.push_back('{2'b10, 32'h0000_A000});
      for (int k = 0; k < 6; k++) dSeq.push_back('{2'b10, 32'h0000_B000 + 32'(k * 64)});
      for (int k = 0; k < 4; k++) expQ.push_back('{1'b1, 1'b0, 32'h0000_B000 + 32'(k * 64)});
      expQ.push_back('{1'b0, 1'b0, 32'h0000_A000});
      expQ.push_back('{1'b1, 1'b0, 32'h0000_B100});
      expQ.push_back('{1'b1, 1'b0, 32'h0000_B140});
      waitIdle(150, "starvation");

      // Writeback reaches the starve limit, yet its refill still goes next, then I$.
      doReset();
      iSeq.push_back('{2'b10, 32'h0000_C000});
      for (int k = 0; k < 3; k++) begin
         dSeq.push_back('{2'b10, 32'h0000_D000 + 32'(k * 64)});
         expQ.push_back('{1'b1, 1'b0, 32'h0000_D000 + 32'(k * 64)});
      end
      dSeq.push_back('{2'b01, 32'h0000_E000});
      dSeq.push_back('{2'b10, 32'h0000_E000});
      expQ.push_back('{1'b1, 1'b1, 32'h0000_E000});
      expQ.push_back('{1'b1, 1'b0, 32'h0000_E000});
      expQ.push_back('{1'b0, 1'b0, 32'h0000_C000});
      waitIdle(150, "writebackPair");

      // Toggling BusReady: beats and address advance only on ready.
      doReset();
      readyMode = 1'b1;
      dSeq.push_back('{2'b01, 32'h0000_F000});
      expQ.push_back('{1'b1, 1'b1, 32'h0000_F000});
      waitIdle(60, "readyToggle");
      readyMode = 1'b0;

      // Reset in beat 3 of a D$ burst, then a normal I$ fetch.
      doReset();
      dSeq.push_back('{2'b10, 32'h0000_1200});
      expQ.push_back('{1'b1, 1'b0, 32'h0000_1200});
      for (int k = 0; k < 40 && !(inBurst && beatExp == 3); k++) tick();
      chk("reachedBeat3", 32'(inBurst && beatExp == 3), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chkAllZero("midBurstReset");
      iSeq.push_back('{2'b10, 32'h0000_3400});
      expQ.push_back('{1'b0, 1'b0, 32'h0000_3400});
      waitIdle(40, "afterReset");
      chk("afterResetLatency", 32'(startCyc - loadCyc), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cachebusarb.md
# cachebusarb

Two-requester line-transfer arbiter that shares one external bus port between the I$ and D$ cache bus interfaces. It sits between the two caches' CacheBusRW/CacheBusAdr outputs and the bus unit. It grants one whole cache-line burst at a time, drives beat count and beat address, and returns a one-cycle CacheBusAck to the owner. D$ has default priority, with a starvation bound for I$, and a D$ writeback followed by its refill is kept as an uninterrupted pair.

## Interface
Parameters:
- PA_BITS, 32, physical address width
- LINELEN, 512, cache line bits (both caches)
- AHBW, 64, bus data width; BEATS = LINELEN/AHBW, LOGBWPL = $clog2(BEATS)
- STARVE_LIMIT, 4, consecutive D$ grants while I$ waits before I$ is forced

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, all state sampled on rising edge of clk
- ICacheBusRW  in  2  I$ request, [1] fetch (bit 0 ignored: read-only)
- ICacheBusAdr  in  PA_BITS  I$ line-aligned address
- DCacheBusRW  in  2  D$ request, [1] fetch, [0] writeback
- DCacheBusAdr  in  PA_BITS  D$ line-aligned address
- BusReady  in  1  current beat accepted by bus unit
- BusValid  out  1  beat request active
- BusWrite  out  1  current burst is a writeback
- BusAdr  out  PA_BITS  line address + BeatCount*(AHBW/8)
- BeatCount  out  LOGBWPL  beat index within burst
- SelBusBeat  out  1  D$ owns bus in write burst (D$ indexes word by BeatCount)
- IGrant, DGrant  out  1 each  current owner (one-hot or zero)
- ICacheBusAck, DCacheBusAck  out  1 each  last beat done, one-cycle pulse

## Operation
- States: IDLE, BURST. Owner register (I/D), Write register, BeatCount, StarveCnt, PairPend.
- IDLE: if any request, latch winner, Write, and address; go to BURST. Otherwise stay.
- Winner selection, in priority order:
  1. PairPend and DCacheBusRW != 0 → D$.
  2. ICacheBusRW[1] and StarveCnt == STARVE_LIMIT → I$.
  3. DCacheBusRW != 0 → D$.
  4. ICacheBusRW[1] → I$.
- D$ RW == 2'b11: treated as writeback (Write = 1).
- BURST: BusValid = 1. On BusReady, BeatCount increments. On BusReady with BeatCount == BEATS-1:
  - pulse owner Ack combinationally the same cycle;
  - clear BeatCount to 0;
  - go to IDLE.
- PairPend is set on D$ write-burst completion and cleared on the next IDLE cycle, whether or not D$ is granted.
- StarveCnt increments, saturating at STARVE_LIMIT, on each D$ grant made while ICacheBusRW[1] = 1. It clears on any I$ grant.
- Bursts are never aborted: a requester dropping RW mid-burst does not stop the transfer, and Ack still pulses.
- Grant outputs and SelBusBeat follow the owner register. SelBusBeat = DGrant & Write & BURST.

## Timing
- Reset: state IDLE, BeatCount 0, StarveCnt 0, PairPend 0. All outputs 0, BusAdr 0.
- Request sampled in IDLE at cycle n → BusValid, grant at n+1.
- Zero-wait line transfer is 1 + BEATS cycles. Back-to-back bursts always have exactly one IDLE cycle.
- Ack is asserted only in the cycle of the final BusReady, never in IDLE.
- BusAdr, BusWrite, and Owner are stable for the whole burst; input address changes mid-burst are ignored.
- StarveCnt width is $clog2(STARVE_LIMIT+1). BeatCount wraps to 0 only via the last-beat rule.
- Reset asserted mid-burst returns to IDLE next edge with no Ack.

## Structure
- Burst state enum (IDLE, BURST) and owner encoding go in the cvw package as typedefs shared with the bus unit.
- BEATS and LOGBWPL are localparams.
- One sub-module: cachebusarbsel, the combinational winner-select (inputs RW pair, StarveCnt, PairPend; outputs winner, write).

## Test plan
- Solo I$ fetch, LINELEN=512, AHBW=64, BusReady=1: BusValid cycles 1–8, BusAdr steps by 8, ICacheBusAck at cycle 8 only.
- Simultaneous I$ and D$ fetch at cycle 0: D$ granted first, I$ granted one cycle after D$ Ack, StarveCnt=1 then 0.
- D$ writeback (RW=01) then refill (RW=10) while I$ waits, StarveCnt=STARVE_LIMIT:
  - D$ refill wins the IDLE after writeback (PairPend);
  - I$ is granted next;
  - SelBusBeat is high only during the writeback.
- D$ requests continuously, I$ fetch pending: I$ is granted after exactly 4 D$ bursts (STARVE_LIMIT=4).
- BusReady toggling 1,0,1,0: BeatCount advances only on ready; Ack on the 8th ready; address is held during wait cycles.
- Reset at beat 3 of a D$ burst: next cycle IDLE with all outputs 0 and no Ack; a new I$ request is granted normally.
